// File: rtl/risc16_fetch_if.sv
// Instruction-memory request/acknowledge bus between the RiSC-16 fetch stage
// and instruction memory.
interface risc16_fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/risc16_fetch.sv
// RiSC-16 instruction fetch stage: PC, instruction register, field decode,
// next-PC selection and retired-instruction counter.
module risc16_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    risc16_fetch_if.master        imem,
    output logic [15:0]           instr,
    output logic [2:0]            op,
    output logic [2:0]            rA,
    output logic [2:0]            rB,
    output logic [2:0]            rC,
    output logic [15:0]           imm7,
    output logic [15:0]           imm10,
    output logic [15:0]           pc,
    output logic [15:0]           pc_plus1,
    output logic                  instr_valid,
    input  logic                  exec_ack,
    input  logic [1:0]            MUX_pc,
    input  logic [15:0]           jalr_tgt,
    output logic                  halted,
    output logic [15:0]           instret
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] pc_q;
    logic [15:0] pc_nx;
    logic [15:0] instr_q;
    logic [15:0] instret_q;
    logic        fetch_done;
    logic        retire;
    logic        is_halt;

    assign instr    = instr_q;
    assign op       = instr_q[15:13];
    assign rA       = instr_q[12:10];
    assign rB       = instr_q[9:7];
    assign rC       = instr_q[2:0];
    assign imm7     = {{9{instr_q[6]}}, instr_q[6:0]};
    assign imm10    = {instr_q[9:0], 6'b0};
    assign pc       = pc_q;
    assign pc_plus1 = pc_q + 16'd1;
    assign instret  = instret_q;

    assign imem.imem_addr = pc_q;

    assign fetch_done = (state == FETCH) && imem.imem_ack;
    assign retire     = (state == ISSUE) && exec_ack;
    // HALT shares op 111 with JALR; a nonzero low field marks HALT.
    assign is_halt    = (instr_q[15:13] == 3'b111) && (instr_q[6:0] != 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FETCH: if (imem.imem_ack) state_nx = ISSUE;
            ISSUE: if (exec_ack) state_nx = is_halt ? HALT : FETCH;
            HALT:  state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        unique case (state)
            FETCH: imem.imem_req = !rst;
            ISSUE: instr_valid   = 1'b1;
            HALT:  halted        = 1'b1;
            default: ;
        endcase
    end

    // Reserved select 11 falls back to sequential flow.
    always_comb begin
        pc_nx = pc_plus1;
        unique case (1'b1)
            MUX_pc == 2'b01: pc_nx = pc_plus1 + imm7;
            MUX_pc == 2'b10: pc_nx = jalr_tgt;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            instret_q <= 16'h0000;
        end else begin
            if (fetch_done) begin
                instr_q <= imem.imem_rdata;
            end
            if (retire) begin
                instret_q <= instret_q + 16'd1;
                if (!is_halt) begin
                    pc_q <= pc_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_risc16_fetch.sv
// Scoreboard bench for risc16_fetch: expected fetch addresses are queued on
// each retirement and popped when the next request is observed.
module tb_risc16_fetch;

    localparam logic [15:0] W_ADD  = 16'h0481;
    localparam logic [15:0] W_ADDI = 16'h2885;
    localparam logic [15:0] W_NAND = 16'h4D03;
    localparam logic [15:0] W_JALR = 16'hE480;
    localparam logic [15:0] W_BEQ  = 16'hC57E;
    localparam logic [15:0] W_HALT = 16'hE001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [2:0]  op;
    logic [2:0]  rA;
    logic [2:0]  rB;
    logic [2:0]  rC;
    logic [15:0] imm7;
    logic [15:0] imm10;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        instr_valid;
    logic        exec_ack;
    logic [1:0]  MUX_pc;
    logic [15:0] jalr_tgt;
    logic        halted;
    logic [15:0] instret;

    risc16_fetch_if bus ();

    risc16_fetch #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .instr      (instr),
        .op         (op),
        .rA         (rA),
        .rB         (rB),
        .rC         (rC),
        .imm7       (imm7),
        .imm10      (imm10),
        .pc         (pc),
        .pc_plus1   (pc_plus1),
        .instr_valid(instr_valid),
        .exec_ack   (exec_ack),
        .MUX_pc     (MUX_pc),
        .jalr_tgt   (jalr_tgt),
        .halted     (halted),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_instret;
    bit          m_halt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic check_fields();
        check("instr", 32'(instr), 32'(m_instr));
        check("pc", 32'(pc), 32'(m_pc));
        check("pc_plus1", 32'(pc_plus1), 32'(16'(m_pc + 16'd1)));
        check("op", 32'(op), 32'(m_instr[15:13]));
        check("rA", 32'(rA), 32'(m_instr[12:10]));
        check("rB", 32'(rB), 32'(m_instr[9:7]));
        check("rC", 32'(rC), 32'(m_instr[2:0]));
        check("imm7", 32'(imm7), 32'({{9{m_instr[6]}}, m_instr[6:0]}));
        check("imm10", 32'(imm10), 32'({m_instr[9:0], 6'b000000}));
    endtask

    task automatic do_reset(input bit ack_in_rst);
        rst = 1'b1;
        exec_ack = 1'b0;
        MUX_pc = 2'b00;
        jalr_tgt = 16'h0000;
        bus.imem_ack = ack_in_rst;
        bus.imem_rdata = 16'hBEEF;
        #1;
        check("rst_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_instr", 32'(instr), 32'h0000);
        check("rst_instret", 32'(instret), 32'h0000);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        #1;
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        m_pc = 16'h0000;
        m_instr = 16'h0000;
        m_instret = 16'h0000;
        m_halt = 1'b0;
        exp_addr_q.delete();
        exp_addr_q.push_back(16'h0000);
    endtask

    task automatic fetch(input logic [15:0] w, input int waits, input bit spur);
        logic [15:0] a;
        int n;
        n = 0;
        while (!bus.imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("sb_depth", 32'(exp_addr_q.size()), 32'd1);
        a = 16'h0000;
        if (exp_addr_q.size() != 0) a = exp_addr_q.pop_front();
        check("fetch_addr", 32'(bus.imem_addr), 32'(a));
        for (int i = 0; i < waits; i++) begin
            if (spur) begin
                exec_ack = 1'b1;
                MUX_pc = 2'b10;
                jalr_tgt = 16'hDEAD;
            end
            @(negedge clk);
            exec_ack = 1'b0;
            MUX_pc = 2'b00;
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_addr", 32'(bus.imem_addr), 32'(a));
            check("stall_valid", 32'(instr_valid), 32'd0);
            check("stall_instret", 32'(instret), 32'(m_instret));
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = w;
        m_instr = w;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_req", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic issue(input logic [1:0] mux, input logic [15:0] tgt,
                         input int waits, input bit spur);
        logic [15:0] nx;
        check_fields();
        for (int i = 0; i < waits; i++) begin
            exec_ack = 1'b0;
            MUX_pc = 2'($urandom);
            jalr_tgt = 16'($urandom);
            if (spur) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 16'hBEEF;
            end
            @(negedge clk);
            bus.imem_ack = 1'b0;
            bus.imem_rdata = 16'h0000;
            check_fields();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_req", 32'(bus.imem_req), 32'd0);
        end
        exec_ack = 1'b1;
        MUX_pc = mux;
        jalr_tgt = tgt;
        case (mux)
            2'b01:   nx = m_pc + 16'd1 + {{9{m_instr[6]}}, m_instr[6:0]};
            2'b10:   nx = tgt;
            default: nx = m_pc + 16'd1;
        endcase
        m_instret = m_instret + 16'd1;
        if (m_instr[15:13] == 3'b111 && m_instr[6:0] != 7'd0) begin
            m_halt = 1'b1;
        end else begin
            m_pc = nx;
            exp_addr_q.push_back(nx);
        end
        @(negedge clk);
        exec_ack = 1'b0;
        MUX_pc = 2'b00;
        jalr_tgt = 16'h0000;
        check("retire_valid", 32'(instr_valid), 32'd0);
        check("instret", 32'(instret), 32'(m_instret));
        check("halted", 32'(halted), 32'(m_halt));
        check("next_req", 32'(bus.imem_req), 32'(!m_halt));
        check("next_pc", 32'(pc), 32'(m_pc));
    endtask

    task automatic halt_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ack = 1'($urandom);
            bus.imem_rdata = 16'h0481;
            exec_ack = 1'b1;
            MUX_pc = 2'b10;
            jalr_tgt = 16'h5555;
            @(negedge clk);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(bus.imem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_pc", 32'(pc), 32'h1234);
            check("halt_instret", 32'(instret), 32'(m_instret));
        end
        bus.imem_ack = 1'b0;
        exec_ack = 1'b0;
        MUX_pc = 2'b00;
        jalr_tgt = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        exec_ack = 1'b0;
        MUX_pc = 2'b00;
        jalr_tgt = 16'h0000;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        m_pc = 16'h0000;
        m_instr = 16'h0000;
        m_instret = 16'h0000;
        m_halt = 1'b0;
        @(negedge clk);
        do_reset(1'b1);

        // Straight-line code, zero-wait.
        fetch(W_ADD, 0, 1'b0);  issue(2'b00, 16'h0, 0, 1'b0);
        fetch(W_ADDI, 0, 1'b0); issue(2'b00, 16'h0, 0, 1'b0);
        fetch(W_NAND, 0, 1'b0); issue(2'b00, 16'h0, 0, 1'b0);
        check("instret_three", 32'(instret), 32'd3);

        // Branches around 0x0010, then JALR to 0x1234 and HALT.
        fetch(W_JALR, 0, 1'b0); issue(2'b10, 16'h0010, 0, 1'b0);
        fetch(W_BEQ, 0, 1'b0);  issue(2'b01, 16'h0, 0, 1'b0);
        check("beq_taken", 32'(bus.imem_addr), 32'h000F);
        fetch(W_ADD, 0, 1'b0);  issue(2'b11, 16'h0, 0, 1'b0);
        fetch(W_BEQ, 0, 1'b0);  issue(2'b00, 16'h0, 0, 1'b0);
        check("beq_not_taken", 32'(bus.imem_addr), 32'h0011);
        fetch(W_JALR, 0, 1'b0); issue(2'b10, 16'h0005, 0, 1'b0);
        fetch(W_JALR, 0, 1'b0); issue(2'b10, 16'h1234, 0, 1'b0);
        check("jalr_addr", 32'(bus.imem_addr), 32'h1234);
        fetch(W_HALT, 0, 1'b0); issue(2'b10, 16'h4444, 0, 1'b0);
        halt_hold(20);
        do_reset(1'b0);

        // Wait states with spurious handshakes.
        fetch(W_ADD, 3, 1'b1);  issue(2'b00, 16'h0, 2, 1'b1);
        fetch(W_ADDI, 1, 1'b0); issue(2'b01, 16'h0, 1, 1'b0);

        // Reset while in ISSUE.
        fetch(W_JALR, 0, 1'b0);
        do_reset(1'b0);

        // Reset in FETCH with an ack landing in the reset cycle.
        fetch(W_ADD, 0, 1'b0);  issue(2'b00, 16'h0, 0, 1'b0);
        fetch(W_JALR, 0, 1'b0); issue(2'b10, 16'h0077, 0, 1'b0);
        @(negedge clk);
        do_reset(1'b1);

        // PC wrap at 0xFFFF.
        fetch(W_JALR, 0, 1'b0); issue(2'b10, 16'hFFFF, 0, 1'b0);
        fetch(W_ADD, 0, 1'b0);  issue(2'b00, 16'h0, 0, 1'b0);
        check("pc_wrap", 32'(pc), 32'h0000);

        // Retired-instruction counter wrap.
        force dut.instret_q = 16'hFFFF;
        #1;
        release dut.instret_q;
        m_instret = 16'hFFFF;
        fetch(W_NAND, 0, 1'b0); issue(2'b00, 16'h0, 0, 1'b0);
        check("instret_wrap", 32'(instret), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
